// File: rtl/control_unit.sv
`default_nettype none
// control_unit: main/ALU decode, condition evaluation against stored NZCV,
// and the sticky undefined-instruction flag for the single-cycle ARM-subset core.
module control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        ALUSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl,
  output logic        Undef
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic       s_bit;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign cmd       = funct[4:1];
  assign s_bit     = funct[0];
  assign unused_rn = ^Instr[7:4];

  logic       reg_w;
  logic       mem_w;
  logic       branch;
  logic       undef_instr;
  logic [1:0] flag_w;
  logic [1:0] flags_nz;
  logic [1:0] flags_cv;
  logic       undef_q;
  logic       cond_ex;
  logic       pcs;

  always_comb begin
    reg_w       = 1'b0;
    mem_w       = 1'b0;
    branch      = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrc      = 1'b0;
    ImmSrc      = 2'b00;
    RegSrc      = 2'b00;
    ALUControl  = 2'b00;
    flag_w      = 2'b00;
    undef_instr = 1'b0;
    case (op)
      2'b00: begin
        reg_w  = 1'b1;
        ALUSrc = funct[5];
        case (cmd)
          4'b0100: begin ALUControl = 2'b00; flag_w = {s_bit, s_bit}; end
          4'b0010: begin ALUControl = 2'b01; flag_w = {s_bit, s_bit}; end
          4'b0000: begin ALUControl = 2'b10; flag_w = {s_bit, 1'b0};  end
          4'b1100: begin ALUControl = 2'b11; flag_w = {s_bit, 1'b0};  end
          4'b1010: begin
            ALUControl  = 2'b01;
            reg_w       = 1'b0;
            flag_w      = 2'b11;
            undef_instr = ~s_bit;
          end
          default: undef_instr = 1'b1;
        endcase
        // Undefined data-processing encodings must look exactly like Op=11
        if (undef_instr) begin
          reg_w      = 1'b0;
          ALUSrc     = 1'b0;
          ALUControl = 2'b00;
          flag_w     = 2'b00;
        end
      end
      2'b01: begin
        ALUSrc     = 1'b1;
        ImmSrc     = 2'b01;
        ALUControl = funct[3] ? 2'b00 : 2'b01;
        if (funct[0]) begin
          reg_w    = 1'b1;
          MemtoReg = 1'b1;
        end else begin
          mem_w  = 1'b1;
          RegSrc = 2'b10;
        end
      end
      2'b10: begin
        branch = 1'b1;
        ALUSrc = 1'b1;
        ImmSrc = 2'b10;
        RegSrc = 2'b01;
      end
      default: undef_instr = 1'b1;
    endcase
  end

  logic n_f, z_f, c_f, v_f;
  assign {n_f, z_f} = flags_nz;
  assign {c_f, v_f} = flags_cv;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign pcs      = branch | (reg_w & (rd == 4'hF));
  assign PCSrc    = pcs   & cond_ex & ~reset;
  assign RegWrite = reg_w & cond_ex & ~reset;
  assign MemWrite = mem_w & cond_ex & ~reset;
  assign Undef    = undef_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_nz <= 2'b00;
      flags_cv <= 2'b00;
      undef_q  <= 1'b0;
    end else begin
      if (flag_w[1] & cond_ex) flags_nz <= ALUFlags[3:2];
      if (flag_w[0] & cond_ex) flags_cv <= ALUFlags[1:0];
      if (undef_instr)         undef_q  <= 1'b1;
    end
  end

endmodule
`default_nettype wire
